// File: rtl/keypad_digit_display_if.sv
// Keypad-to-display link: decoded key strobe in, multiplexed segment/anode drive out.
interface keypad_digit_display_if;
  logic [3:0] digit;
  logic       valid_key;
  logic [6:0] seg;
  logic [1:0] an;
  logic [7:0] shown;

  modport master (output digit, valid_key, input seg, an, shown);
  modport slave  (input digit, valid_key, output seg, an, shown);
endinterface

// File: rtl/keypad_digit_display.sv
// Two-digit key history with a time-multiplexed, dead-time separated 7-segment drive.
// Optional build macro DIGIT_DISPLAY_BLANK_EN blanks digits that have never been captured.
module hex7_lane (
  input  logic [3:0] nib,
  input  logic       vis,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (vis) begin
      unique case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
      endcase
    end
  end
endmodule

module keypad_digit_display #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int DEAD_CYCLES    = 240
) (
  input logic                   clk,
  input logic                   reset,
  keypad_digit_display_if.slave bus
);
  localparam int NUM_DIG = 2;
  localparam int MAXC    = (REFRESH_CYCLES > DEAD_CYCLES) ?
                           ((REFRESH_CYCLES > 2) ? REFRESH_CYCLES : 2) :
                           ((DEAD_CYCLES > 2) ? DEAD_CYCLES : 2);
  localparam int CW      = $clog2(MAXC);
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);
  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(HAS_DEAD ? DEAD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {SHOW_R, DEAD_RL, SHOW_L, DEAD_LR} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            valid_q, rise;
  logic [3:0]      left, right;
  logic [NUM_DIG-1:0][3:0] digs;
  logic [NUM_DIG-1:0][6:0] segs;
  logic [NUM_DIG-1:0]      vis;
  logic [6:0]      seg_nx, seg_q;
  logic [1:0]      an_nx, an_q;

  assign rise = bus.valid_key && !valid_q;

  // Capture path: free of the mux FSM so a key never perturbs refresh timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      left    <= 4'h0;
      right   <= 4'h0;
    end else begin
      valid_q <= bus.valid_key;
      if (rise) begin
        left  <= right;
        right <= bus.digit;
      end
    end
  end

`ifdef DIGIT_DISPLAY_BLANK_EN
  logic left_v, right_v;
  always_ff @(posedge clk) begin
    if (reset) begin
      left_v  <= 1'b0;
      right_v <= 1'b0;
    end else if (rise) begin
      left_v  <= right_v;
      right_v <= 1'b1;
    end
  end
  assign vis = {left_v, right_v};
`else
  assign vis = '1;
`endif

  assign digs = {left, right};

  generate
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
      hex7_lane u_hex (.nib(digs[i]), .vis(vis[i]), .seg(segs[i]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW_R;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    logic last;
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    last     = ((state == SHOW_R) || (state == SHOW_L)) ? (cnt == R_LAST) : (cnt == D_LAST);
    if (last) begin
      cnt_nx = '0;
      unique case (state)
        SHOW_R:  state_nx = HAS_DEAD ? DEAD_RL : SHOW_L;
        DEAD_RL: state_nx = SHOW_L;
        SHOW_L:  state_nx = HAS_DEAD ? DEAD_LR : SHOW_R;
        DEAD_LR: state_nx = SHOW_R;
      endcase
    end
  end

  always_comb begin
    an_nx  = 2'b11;
    seg_nx = 7'b1111111;
    unique case (state)
      SHOW_R: begin
        an_nx  = 2'b10;
        seg_nx = segs[0];
      end
      SHOW_L: begin
        an_nx  = 2'b01;
        seg_nx = segs[1];
      end
      default: ;
    endcase
  end

  // Registered drive: both anodes come up off out of reset and lag the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= 2'b11;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_nx;
      seg_q <= seg_nx;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.shown = {left, right};
endmodule

// File: tb/tb_keypad_digit_display.sv
// Randomized bench for keypad_digit_display against a cycle-position reference model.
module tb_keypad_digit_display;
  localparam int R = 4;
  localparam int D = 1;
  localparam int P = 2 * (R + D);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_digit_display_if bus();

  keypad_digit_display #(.REFRESH_CYCLES(R), .DEAD_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: e = clock edges since reset released; digits kept as a 2-deep history.
  int         e = 0;
  logic [3:0] ml = 4'h0, mr = 4'h0;
  bit         mlv = 1'b0, mrv = 1'b0, mvp = 1'b0;
  logic [1:0] exp_an = 2'b11;
  logic [6:0] exp_seg = 7'h7f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig_seg(input logic [3:0] d, input bit v);
    bit blank;
`ifdef DIGIT_DISPLAY_BLANK_EN
    blank = !v;
`else
    blank = v & 1'b0;
`endif
    return blank ? 7'b1111111 : hex_tbl[d];
  endfunction

  task automatic cyc();
    logic r_s, vk;
    logic [3:0] d;
    int p;
    r_s = reset;
    vk  = bus.valid_key;
    d   = bus.digit;
    @(posedge clk);
    if (r_s) begin
      e = 0; ml = 4'h0; mr = 4'h0; mlv = 1'b0; mrv = 1'b0; mvp = 1'b0;
      exp_an = 2'b11; exp_seg = 7'h7f;
    end else begin
      p = e % P;
      e++;
      if (p < R) begin
        exp_an = 2'b10; exp_seg = dig_seg(mr, mrv);
      end else if (p < R + D) begin
        exp_an = 2'b11; exp_seg = 7'h7f;
      end else if (p < 2 * R + D) begin
        exp_an = 2'b01; exp_seg = dig_seg(ml, mlv);
      end else begin
        exp_an = 2'b11; exp_seg = 7'h7f;
      end
      if (vk && !mvp) begin
        ml = mr; mr = d; mlv = mrv; mrv = 1'b1;
      end
      mvp = vk;
    end
    @(negedge clk);
    chk("an", 32'(bus.an), 32'(exp_an));
    chk("seg", 32'(bus.seg), 32'(exp_seg));
    chk("shown", 32'(bus.shown), 32'({ml, mr}));
    chk("an_overlap", 32'(bus.an == 2'b00), 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input logic [3:0] d);
    bus.digit = d;
    bus.valid_key = 1'b1;
    cyc();
    bus.valid_key = 1'b0;
    cyc();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  // Next edge samples the FSM at position e%P; advance until it equals pos (at most P cycles).
  task automatic align(input int pos);
    for (int i = 0; i < P && (e % P) != pos; i++) cyc();
  endtask

  initial begin
    bus.digit = 4'h0;
    bus.valid_key = 1'b0;
    @(negedge clk);

    // Reset and idle refresh pattern
    do_reset(3);
    chk("post_rst_an", 32'(bus.an), 32'(2'b11));
    chk("post_rst_seg", 32'(bus.seg), 32'h7f);
    chk("post_rst_shown", 32'(bus.shown), 32'h00);
    run(2 * P);

    // Single capture
    press(4'h7);
    chk("single_shown", 32'(bus.shown), 32'h07);
    align(0);
    cyc();
    chk("single_seg_r", 32'(bus.seg), 32'(7'b1111000));
    run(P);

    // Two keys
    press(4'hA);
    press(4'h3);
    chk("two_shown", 32'(bus.shown), 32'hA3);
    run(P + 2);

    // Held strobe across a digit change
    do_reset(2);
    bus.digit = 4'h5;
    bus.valid_key = 1'b1;
    run(10);
    bus.digit = 4'h9;
    run(10);
    bus.valid_key = 1'b0;
    cyc();
    chk("held_shown", 32'(bus.shown), 32'h05);

    // Capture while both anodes are off
    align(R);
    press(4'hC);
    run(2 * P);

    // Reset colliding with a valid_key rise while the left digit is lit
    do_reset(1);
    press(4'hA);
    press(4'h3);
    align(R + D + 1);
    reset = 1'b1;
    bus.digit = 4'h5;
    bus.valid_key = 1'b1;
    cyc();
    chk("rst_mid_shown", 32'(bus.shown), 32'h00);
    chk("rst_mid_an", 32'(bus.an), 32'(2'b11));
    reset = 1'b0;
    cyc();
    bus.valid_key = 1'b0;
    cyc();
    chk("rst_first_capture", 32'(bus.shown), 32'h05);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.valid_key = ($urandom_range(0, 3) == 0);
      bus.digit = 4'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;
    bus.valid_key = 1'b0;
    run(P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_digit_display.md
# keypad_digit_display

Consumer end of the keypad scanner's `digit`/`valid_key` interface. It captures each newly decoded hex key into a two-digit history, with the newest digit on the right and the previous digit on the left. It time-multiplexes the dual seven-segment display over one shared active-low segment bus with a dead-time gap between digits. It sits between the keypad FSM and the board's display transistors.

## Interface
- `REFRESH_CYCLES`, default 24000: clock cycles each digit is lit per visit; must be ≥ 1.
- `DEAD_CYCLES`, default 240: clock cycles with both anodes off between digits; 0 removes dead time.
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `digit`  in  4  hex key code from the keypad FSM.
- `valid_key`  in  1  key-accepted strobe from the keypad FSM; may be held for more than one cycle.
- `seg`  out  7  segment drive `{g,f,e,d,c,b,a}`, active low.
- `an`  out  2  anode enables, active low; `an[0]` is the right digit and `an[1]` is the left digit.
- `shown`  out  8  `{left,right}` digit registers, for debug and verification.

## Operation
- **Capture:** `valid_q` holds `valid_key` delayed by one cycle; it resets to 0.
  - On a rising edge (`valid_key && !valid_q`): `left <= right` and `right <= digit`.
  - Holding `valid_key` high captures exactly once.
  - If `valid_key` is already high on the first cycle after reset, that is a capture.
- **FSM states:** `SHOW_R`, `DEAD_RL`, `SHOW_L`, `DEAD_LR`. Reset enters `SHOW_R` with `cnt=0`.
- **Counting and transitions:**
  - In `SHOW_*`, `cnt` counts 0..`REFRESH_CYCLES`-1.
  - In `DEAD_*`, `cnt` counts 0..`DEAD_CYCLES`-1.
  - When `cnt` reaches its limit-1, the FSM advances `SHOW_R→DEAD_RL→SHOW_L→DEAD_LR→SHOW_R` and `cnt` returns to 0.
  - With `DEAD_CYCLES==0`, dead states are skipped: `SHOW_R↔SHOW_L`.
- **Output decode:**
  - `SHOW_R`: `an=2'b10`, `seg=hex(right)`.
  - `SHOW_L`: `an=2'b01`, `seg=hex(left)`.
  - Dead states: `an=2'b11`, `seg=7'b1111111`.
- **Hex table (a–g active low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Independence:** capture is independent of the mux FSM. A capture during any state never resets `cnt` or changes state.
- **Width:** `cnt` is `$clog2(max(REFRESH_CYCLES,DEAD_CYCLES,2))` bits and never wraps past its limit.

## Timing
- **Reset values:** `left=0`, `right=0`, `valid_q=0`, state `SHOW_R`, `cnt=0`, `an=2'b11`, `seg=7'b1111111`, `shown=8'h00`.
- **Registered outputs:** `seg` and `an` are flopped. In cycle n they reflect the state and digit registers of cycle n-1, so the first cycle after reset deassertion still shows `an=2'b11`.
- **Capture latency:**
  - `shown` updates on the clock edge that samples the `valid_key` rise.
  - `seg` reflects the new digit one edge later, if that digit's state is active.
- **Full refresh period:** `2*(REFRESH_CYCLES+DEAD_CYCLES)` cycles.
- **Anode overlap:** `an` never has both bits 0, including across state changes and reset.
- **Reset mid-operation:** reset wins over capture and over state advance on the same edge.

## Configuration
- Macro: `DIGIT_DISPLAY_BLANK_EN`.
- **Defined:**
  - Each digit register carries a valid flag, cleared by reset.
  - Capture sets `right_v` and copies `right_v` into `left_v`.
  - A digit whose flag is 0 shows `seg=7'b1111111`, with its anode still driven per the FSM.
  - After reset the display is blank. After one key, only the right digit is lit.
- **Undefined:** no flags; both digits show "0" after reset.
- `shown` is identical in both builds.

## Test plan
All scenarios use `REFRESH_CYCLES=4`, `DEAD_CYCLES=1`.
- **Reset:** hold `reset` 3 cycles, then release.
  - During reset and on the first post-reset cycle: `an=2'b11`, `seg=7'b1111111`, `shown=8'h00`.
  - Then `an=2'b10` for 4 cycles, `2'b11` for 1, `2'b01` for 4, `2'b11` for 1; period 10 cycles.
- **Single capture:** `digit=4'h7`, `valid_key` high 1 cycle → `shown=8'h07`.
  - In `SHOW_R`, `seg=7'b1111000`.
  - With `DIGIT_DISPLAY_BLANK_EN`, `SHOW_L` shows `seg=7'b1111111`; without it, `1000000`.
- **Two keys:** press `A` then `3` → `shown=8'hA3`.
  - Left digit shows `0001000`; right digit shows `0110000`.
- **Held strobe:** `valid_key` high 20 cycles while `digit` changes from 5 to 9 → exactly one capture, `shown=8'h05`.
- **Capture mid-refresh:** pulse `valid_key` during `DEAD_RL` → FSM timing unchanged; next `SHOW_R` shows the new digit.
  - Assert every cycle that `an!=2'b00`.
- **Reset mid-operation:** assert `reset` while in `SHOW_L` with `shown=8'hA3`, on the same edge as a `valid_key` rise → `shown=8'h00`, state `SHOW_R`, `an=2'b11` next cycle.
